// File: rtl/sat_subtractor_pipe.sv
// sat_subtractor_pipe
//   Two-stage pipelined saturating subtractor, Resta = sat(DataA - DataB),
//   with a ready/valid handshake on both sides and a counter of saturated
//   results delivered downstream.
//
//   Stage S1 holds the full (N+1)-bit difference, so it can never wrap.
//   Stage S2 holds the clamped result and its flags. Clamping is symmetric:
//   the output range is [-(2^(N-1)-1), 2^(N-1)-1].
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous, active-high
//   in_valid   : operand pair present on DataA/DataB
//   in_ready   : operand pair accepted this cycle (combinational)
//   DataA      : signed minuend (setpoint), N bits
//   DataB      : signed subtrahend (feedback), N bits
//   out_valid  : Resta/sat_pos/sat_neg hold a result
//   out_ready  : downstream accepts the result
//   Resta      : saturated difference, N bits signed
//   sat_pos    : result clamped to the positive limit
//   sat_neg    : result clamped to the negative limit
//   cnt_clr    : one-cycle pulse clearing sat_count (wins over increment)
//   sat_count  : saturating count of saturated results delivered, 8 bits
module sat_subtractor_pipe #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] DataA,
  input  logic signed [N-1:0] DataB,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] Resta,
  output logic                sat_pos,
  output logic                sat_neg,
  input  logic                cnt_clr,
  output logic [7:0]          sat_count
);

  // Clamp limits at difference width and at output width.
  localparam logic signed [N:0]   DIFF_MAX = {2'b00, {(N-1){1'b1}}};
  localparam logic signed [N:0]   DIFF_MIN = {2'b11, {(N-2){1'b0}}, 1'b1};
  localparam logic signed [N-1:0] RES_MAX  = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] RES_MIN  = {1'b1, {(N-2){1'b0}}, 1'b1};

  logic                s1_valid;
  logic signed [N:0]   s1_diff;
  logic                s1_load;
  logic                s2_load;
  logic signed [N-1:0] clamp_res;
  logic                clamp_pos;
  logic                clamp_neg;

  // S2 can take a new entry when empty or when its entry leaves this cycle;
  // S1 can take one when empty or when it drains into S2 this cycle.
  always_comb begin
    s2_load  = !out_valid || out_ready;
    s1_load  = !s1_valid || s2_load;
    in_ready = s1_load;
  end

  always_comb begin
    clamp_res = s1_diff[N-1:0];
    clamp_pos = 1'b0;
    clamp_neg = 1'b0;
    if (s1_diff > DIFF_MAX) begin
      clamp_res = RES_MAX;
      clamp_pos = 1'b1;
    end else if (s1_diff < DIFF_MIN) begin
      clamp_res = RES_MIN;
      clamp_neg = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_diff <= {DataA[N-1], DataA} - {DataB[N-1], DataB};
      end
    end
  end

  // Data/flags only move with a valid entry, so an empty slot keeps the
  // reset (or last) value instead of picking up stale S1 contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      Resta     <= '0;
      sat_pos   <= 1'b0;
      sat_neg   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        Resta   <= clamp_res;
        sat_pos <= clamp_pos;
        sat_neg <= clamp_neg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_count <= '0;
    end else if (cnt_clr) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && (sat_pos || sat_neg) && (sat_count != '1)) begin
      sat_count <= sat_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_sat_subtractor_pipe.sv
module tb_sat_subtractor_pipe;

  typedef struct {
    logic signed [7:0] r;
    logic              p;
    logic              n;
  } exp_t;

  typedef struct {
    logic signed [7:0] a;
    logic signed [7:0] b;
    exp_t              e;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] DataA;
  logic signed [7:0] DataB;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] Resta;
  logic              sat_pos;
  logic              sat_neg;
  logic              cnt_clr;
  logic [7:0]        sat_count;

  sat_subtractor_pipe #(.N(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .DataA     (DataA),
    .DataB     (DataB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Resta     (Resta),
    .sat_pos   (sat_pos),
    .sat_neg   (sat_neg),
    .cnt_clr   (cnt_clr),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t cur_exp;
  int   mcount = 0;
  bit   accepted = 1'b0;
  bit   hold_prev = 1'b0;
  logic signed [7:0] prev_r;
  logic prev_p, prev_n;
  int   out_xfers = 0;

  vec_t tbl[14];

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int   d;
    d = a - b;
    if (d > 127) begin
      e.r = 8'sd127; e.p = 1'b1; e.n = 1'b0;
    end else if (d < -127) begin
      e.r = -8'sd127; e.p = 1'b0; e.n = 1'b1;
    end else begin
      e.r = 8'(d); e.p = 1'b0; e.n = 1'b0;
    end
    return e;
  endfunction

  function automatic vec_t mk(input int a, input int b, input int r, input bit p, input bit n);
    vec_t v;
    v.a = 8'(a); v.b = 8'(b);
    v.e.r = 8'(r); v.e.p = p; v.e.n = n;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Observation point, called at the falling edge: records the handshakes
  // that the next rising edge will perform and checks the output side.
  task automatic mon();
    exp_t e;
    if (reset) begin
      q.delete();
      mcount    = 0;
      accepted  = 1'b0;
      hold_prev = 1'b0;
    end else begin
      chk("sat_count", int'(sat_count), mcount);
      if (hold_prev)
        chk("hold_stable", int'({out_valid, Resta, sat_pos, sat_neg}),
            int'({1'b1, prev_r, prev_p, prev_n}));
      accepted = in_valid && in_ready;
      if (accepted) q.push_back(cur_exp);
      if (out_valid && out_ready) begin
        out_xfers++;
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL stray_result: got Resta=%0d with no result pending (t=%0t)", Resta, $time);
        end else begin
          e = q.pop_front();
          chk("result", int'({Resta, sat_pos, sat_neg}), int'({e.r, e.p, e.n}));
          if ((e.p || e.n) && mcount < 255) mcount++;
        end
      end
      if (cnt_clr) mcount = 0;
      hold_prev = out_valid && !out_ready;
      prev_r = Resta; prev_p = sat_pos; prev_n = sat_neg;
    end
  endtask

  // One cycle: observe at negedge, return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [7:0] a, input logic signed [7:0] b, input exp_t e);
    in_valid = 1'b1; DataA = a; DataB = b; cur_exp = e;
    for (int t = 0; t < 50; t++) begin
      tick();
      if (accepted) break;
    end
    chk("send_accepted", int'(accepted), 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 20 && (q.size() != 0 || out_valid); t++) tick();
    chk("drain_pending", q.size(), 0);
  endtask

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int x0;
    vec_t items[4];

    tbl[0]  = mk(5, 3, 2, 0, 0);
    tbl[1]  = mk(100, -50, 127, 1, 0);
    tbl[2]  = mk(-100, 100, -127, 0, 1);
    tbl[3]  = mk(-128, 0, -127, 0, 1);
    tbl[4]  = mk(127, -128, 127, 1, 0);
    tbl[5]  = mk(-128, 127, -127, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0);
    tbl[7]  = mk(-1, -1, 0, 0, 0);
    tbl[8]  = mk(127, 0, 127, 0, 0);
    tbl[9]  = mk(-127, 0, -127, 0, 0);
    tbl[10] = mk(-127, 1, -127, 0, 1);
    tbl[11] = mk(126, -1, 127, 0, 0);
    tbl[12] = mk(0, 127, -127, 0, 0);
    tbl[13] = mk(0, -128, 127, 1, 0);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    DataA = '0; DataB = '0; cur_exp = model(0, 0);
    tick();
    tick();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_resta", int'(Resta), 0);
    chk("rst_flags", int'({sat_pos, sat_neg}), 0);
    chk("rst_sat_count", int'(sat_count), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    reset = 1'b0;
    tick();

    // Latency: the accepting edge is the first of two edges to out_valid.
    send(8'sd5, 8'sd3, model(5, 3));
    chk("lat_not_yet", int'(out_valid), 0);
    tick();
    chk("lat_out_valid", int'(out_valid), 1);
    chk("lat_resta", int'(Resta), 2);
    chk("lat_flags", int'({sat_pos, sat_neg}), 0);
    drain();

    // Saturation count over three clamped results.
    pulse_clr();
    send(8'sd100, -8'sd50, model(100, -50));
    send(-8'sd100, 8'sd100, model(-100, 100));
    send(-8'sd128, 8'sd0, model(-128, 0));
    drain();
    tick();
    chk("sat3_count", int'(sat_count), 3);

    // Table vectors, back to back.
    for (int i = 0; i < 14; i++) send(tbl[i].a, tbl[i].b, tbl[i].e);
    drain();

    // Backpressure: 4 offered back to back with out_ready low for 4 cycles.
    items[0] = mk(10, 20, -10, 0, 0);
    items[1] = mk(-5, 7, -12, 0, 0);
    items[2] = mk(60, -70, 127, 1, 0);
    items[3] = mk(-90, 50, -127, 0, 1);
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1; DataA = items[0].a; DataB = items[0].b; cur_exp = items[0].e;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) begin
        chk("bp_accepted", idx, 2);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_out_valid", int'(out_valid), 1);
        chk("bp_resta_head", int'(Resta), -10);
        out_ready = 1'b1;
        x0 = out_xfers;
      end
      tick();
      if (accepted) idx++;
      if (idx < 4) begin
        DataA = items[idx].a; DataB = items[idx].b; cur_exp = items[idx].e;
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("bp_all_accepted", idx, 4);
    chk("bp_one_per_cycle", out_xfers - x0, 4);
    drain();

    // Counter saturation, then clear coincident with a saturated transfer.
    pulse_clr();
    for (int i = 0; i < 300; i++) send(8'sd100, -8'sd100, model(100, -100));
    drain();
    tick();
    chk("cnt_full", int'(sat_count), 255);
    out_ready = 1'b0;
    send(-8'sd100, 8'sd100, model(-100, 100));
    tick();
    chk("clr_pending", int'(out_valid && sat_neg), 1);
    cnt_clr = 1'b1; out_ready = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_wins", int'(sat_count), 0);
    send(8'sd120, -8'sd120, model(120, -120));
    drain();
    tick();
    chk("cnt_after_clr", int'(sat_count), 1);

    // Reset with both stages full.
    out_ready = 1'b0;
    send(8'sd1, 8'sd2, model(1, 2));
    send(8'sd3, 8'sd4, model(3, 4));
    chk("full_in_ready", int'(in_ready), 0);
    reset = 1'b1;
    tick();
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_resta", int'(Resta), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_count", int'(sat_count), 0);
    tick();
    chk("mid_rst_in_ready2", int'(in_ready), 1);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    chk("no_stale_out_valid", int'(out_valid), 0);
    send(-8'sd7, 8'sd9, model(-7, 9));
    drain();

    // Random operands with random handshakes.
    in_valid = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (!in_valid || accepted) begin
        in_valid = ($urandom_range(0, 3) != 0);
        DataA = 8'($urandom);
        DataB = 8'($urandom);
        cur_exp = model(DataA, DataB);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0;
    drain();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
